pipe_ctrl: RTL and testbench

Hazard and stall sequencer for the 5-stage 16-bit WISC pipeline.
- Drives the write-enable, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and applies taken-branch flushes.
- Freezes or bubbles stages during I-cache/D-cache misses, halts on HLT and counts stall cycles.
- Sits beside the datapath in cpu top; no datapath values pass through it.

---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/pipe_ctrl_hazard_detect.sv | 24 ++
 rtl/pipe_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the WISC pipeline controller: opcode constants,
// controller state encoding, instruction field layout and register-read
// decode helpers used by hazard detection.
package pipe_pkg;

    localparam int unsigned INST_W = 16;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_LW  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SW  = 4'b1001;
    localparam logic [OP_W-1:0] OP_LLB = 4'b1010;
    localparam logic [OP_W-1:0] OP_LHB = 4'b1011;
    localparam logic [OP_W-1:0] OP_BR  = 4'b1100;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IMISS = 2'd1,
        ST_DMISS = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0] opcode;
        logic [3:0]      rd;
        logic [3:0]      rs;
        logic [3:0]      rt;
    } inst_t;

    // ALU ops (0000-0111), LW, SW and 1101 source rs
    function automatic logic reads_rs(input logic [OP_W-1:0] op);
        return (op <= OP_SW) || (op == 4'b1101);
    endfunction

    function automatic logic reads_rt(input logic [OP_W-1:0] op);
        return (op <= 4'b0011) || (op == 4'b0111);
    endfunction

    // SW reads store data from rd; LLB/LHB merge into the existing rd
    function automatic logic reads_rd(input logic [OP_W-1:0] op);
        return (op == OP_SW) || (op == OP_LLB) || (op == OP_LHB);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use detector.
// Ports: ifid_inst_i (instruction in ID), idex_inst_i (instruction in EX),
//        load_use_c_o (ID instruction reads the register an EX-stage LW writes).
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [INST_W-1:0] ifid_inst_i,
    input  logic [INST_W-1:0] idex_inst_i,
    output logic              load_use_c_o
);

    inst_t id_inst;
    inst_t ex_inst;

    assign id_inst = inst_t'(ifid_inst_i);
    assign ex_inst = inst_t'(idex_inst_i);

    // R0 is an ordinary register, so no zero-register exclusion
    assign load_use_c_o = (ex_inst.opcode == OP_LW) &&
                          ((reads_rs(id_inst.opcode) && (id_inst.rs == ex_inst.rd)) ||
                           (reads_rt(id_inst.opcode) && (id_inst.rt == ex_inst.rd)) ||
                           (reads_rd(id_inst.opcode) && (id_inst.rd == ex_inst.rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/stall sequencer for the 5-stage WISC pipeline.
// Inputs : clk, rst (async active-low), ifid_inst/idex_inst, branch_taken,
//          icache_miss/icache_done, dcache_miss/dcache_done, wb_halt.
// Outputs: per-stage write enables, ifid_flush, idex_bubble (combinational
//          from state and inputs), halted, stall_cnt, tmo_err.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MISS_TMO = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] ifid_inst,
    input  logic [INST_W-1:0] idex_inst,
    input  logic              branch_taken,
    input  logic              icache_miss,
    input  logic              icache_done,
    input  logic              dcache_miss,
    input  logic              dcache_done,
    input  logic              wb_halt,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_bubble,
    output logic              exmem_write,
    output logic              memwb_write,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              tmo_err
);

    localparam int unsigned MC_W = (MISS_TMO < 2) ? 1 : $clog2(MISS_TMO + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [MC_W-1:0]   miss_cyc_q, miss_cyc_d;
    logic              tmo_err_q, tmo_err_d;
    logic              load_use;
    logic              in_miss;

    hazard_detect u_hazard (
        .ifid_inst_i  (ifid_inst),
        .idex_inst_i  (idex_inst),
        .load_use_c_o (load_use)
    );

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            miss_cyc_q  <= '0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            miss_cyc_q  <= miss_cyc_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    // Next state and pipeline controls
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        exmem_write = 1'b1;
        memwb_write = 1'b1;
        halted      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (wb_halt) begin
                    // this cycle still advances so the HLT retires
                    state_d = ST_HALT;
                end else if (dcache_miss) begin
                    state_d     = ST_DMISS;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                    memwb_write = 1'b0;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (icache_miss) begin
                    state_d    = ST_IMISS;
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                end
            end
            ST_DMISS: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
                memwb_write = 1'b0;
                if (dcache_done) begin
                    state_d = icache_miss ? ST_IMISS : ST_RUN;
                end
            end
            ST_IMISS: begin
                if (dcache_miss) begin
                    state_d     = ST_DMISS;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                    memwb_write = 1'b0;
                end else if (load_use) begin
                    // hold the stalled instruction in ID rather than flushing it
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (icache_done) state_d = ST_RUN;
                end else if (branch_taken) begin
                    // redirect; the fill in flight was for the old path
                    ifid_flush = 1'b1;
                end else begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    if (icache_done) state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
                memwb_write = 1'b0;
                halted      = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign in_miss = (state_q == ST_IMISS) || (state_q == ST_DMISS);

    // Stall counter, miss-duration counter and sticky timeout
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        miss_cyc_d  = '0;
        tmo_err_d   = tmo_err_q;

        if (!pc_write && (state_q != ST_HALT) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (in_miss) begin
            miss_cyc_d = miss_cyc_q;
            if (32'(miss_cyc_q) < MISS_TMO) begin
                miss_cyc_d = miss_cyc_q + MC_W'(1);
            end
            if ((MISS_TMO != 0) && ((32'(miss_cyc_q) + 32'd1) >= MISS_TMO)) begin
                tmo_err_d = 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a per-cycle vector table for the single- and
// multi-cycle hazard/miss sequences, plus hand sequences for timeout,
// counter saturation, async reset mid-miss and halt.
module tb_pipe_ctrl;

    localparam int unsigned CNT_W    = 6;
    localparam int unsigned MISS_TMO = 8;
    localparam int unsigned NVEC     = 32;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_write}
    localparam logic [6:0] RA = 7'b1101011;
    localparam logic [6:0] LU = 7'b0001111;
    localparam logic [6:0] IM = 7'b0111011;
    localparam logic [6:0] BR = 7'b1111011;
    localparam logic [6:0] FZ = 7'b0000000;

    typedef struct {
        logic [15:0]      ifid;
        logic [15:0]      idex;
        logic             br;
        logic             im;
        logic             id;
        logic             dm;
        logic             dd;
        logic [6:0]       ctrl;
        logic [CNT_W-1:0] sc;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [15:0]      ifid_inst;
    logic [15:0]      idex_inst;
    logic             branch_taken;
    logic             icache_miss;
    logic             icache_done;
    logic             dcache_miss;
    logic             dcache_done;
    logic             wb_halt;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_write;
    logic             memwb_write;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic             tmo_err;

    int   n_vec;
    int   n_err;
    vec_t tbl [NVEC];

    pipe_ctrl #(.CNT_W(CNT_W), .MISS_TMO(MISS_TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifid_inst    (ifid_inst),
        .idex_inst    (idex_inst),
        .branch_taken (branch_taken),
        .icache_miss  (icache_miss),
        .icache_done  (icache_done),
        .dcache_miss  (dcache_miss),
        .dcache_done  (dcache_done),
        .wb_halt      (wb_halt),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_write   (idex_write),
        .idex_bubble  (idex_bubble),
        .exmem_write  (exmem_write),
        .memwb_write  (memwb_write),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .tmo_err      (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic [15:0] ifid, input logic [15:0] idex,
                               input logic br, input logic im, input logic id,
                               input logic dm, input logic dd,
                               input logic [6:0] ctrl, input int sc);
        vec_t r;
        r.ifid = ifid; r.idex = idex;
        r.br = br; r.im = im; r.id = id; r.dm = dm; r.dd = dd;
        r.ctrl = ctrl; r.sc = CNT_W'(sc);
        return r;
    endfunction

    task automatic drive(input logic [15:0] ifid, input logic [15:0] idex,
                         input logic br, input logic im, input logic id,
                         input logic dm, input logic dd, input logic hlt);
        @(negedge clk);
        ifid_inst = ifid; idex_inst = idex;
        branch_taken = br; icache_miss = im; icache_done = id;
        dcache_miss = dm; dcache_done = dd; wb_halt = hlt;
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input int idx, input logic [6:0] ctrl,
                             input logic hlt, input int sc, input logic tmo);
        chk({nm, ".ctrl"}, idx, 32'({pc_write, ifid_write, ifid_flush, idex_write,
                                     idex_bubble, exmem_write, memwb_write}), 32'(ctrl));
        chk({nm, ".halted"},    idx, 32'(halted),    32'(hlt));
        chk({nm, ".stall_cnt"}, idx, 32'(stall_cnt), 32'(sc));
        chk({nm, ".tmo_err"},   idx, 32'(tmo_err),   32'(tmo));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        ifid_inst = '0; idex_inst = '0;
        branch_taken = 1'b0; icache_miss = 1'b0; icache_done = 1'b0;
        dcache_miss = 1'b0; dcache_done = 1'b0; wb_halt = 1'b0;

        tbl[0]  = v(16'h0000, 16'h0000, 0, 0, 0, 0, 0, RA, 0);
        tbl[1]  = v(16'h0000, 16'h0000, 0, 0, 0, 0, 0, RA, 0);
        tbl[2]  = v(16'h0135, 16'h8310, 0, 0, 0, 0, 0, LU, 0);  // ADD R1,R3,R5 after LW R3
        tbl[3]  = v(16'h0135, 16'h0000, 0, 0, 0, 0, 0, RA, 1);
        tbl[4]  = v(16'h0000, 16'h0000, 1, 0, 0, 0, 0, BR, 1);
        tbl[5]  = v(16'h0000, 16'h0000, 0, 0, 0, 0, 0, RA, 1);
        tbl[6]  = v(16'h0135, 16'h8310, 1, 0, 0, 0, 0, LU, 1);  // hazard beats branch
        tbl[7]  = v(16'h0000, 16'h0000, 0, 0, 0, 0, 0, RA, 2);
        tbl[8]  = v(16'h9350, 16'h8310, 0, 0, 0, 0, 0, LU, 2);  // SW data reg rd
        tbl[9]  = v(16'hA300, 16'h8310, 0, 0, 0, 0, 0, LU, 3);  // LLB reads rd
        tbl[10] = v(16'h4013, 16'h8310, 0, 0, 0, 0, 0, RA, 4);  // op 4 ignores rt
        tbl[11] = v(16'h7013, 16'h8310, 0, 0, 0, 0, 0, LU, 4);  // op 7 reads rt
        tbl[12] = v(16'hC030, 16'h8310, 0, 0, 0, 0, 0, RA, 5);  // op C ignores rs
        tbl[13] = v(16'hD030, 16'h8310, 0, 0, 0, 0, 0, LU, 5);  // op D reads rs
        tbl[14] = v(16'h0135, 16'h0310, 0, 0, 0, 0, 0, RA, 6);  // producer not LW
        tbl[15] = v(16'h0100, 16'h8000, 0, 0, 0, 0, 0, LU, 6);  // R0 dependency
        tbl[16] = v(16'h0000, 16'h0000, 0, 0, 1, 0, 1, RA, 7);  // stray done pulses
        tbl[17] = v(16'h0000, 16'h0000, 0, 1, 0, 1, 0, FZ, 7);
        tbl[18] = v(16'h0000, 16'h0000, 0, 1, 0, 1, 0, FZ, 8);
        tbl[19] = v(16'h0000, 16'h0000, 0, 1, 0, 1, 0, FZ, 9);
        tbl[20] = v(16'h0000, 16'h0000, 0, 1, 0, 1, 0, FZ, 10);
        tbl[21] = v(16'h0000, 16'h0000, 0, 1, 0, 1, 1, FZ, 11);
        tbl[22] = v(16'h0000, 16'h0000, 0, 1, 0, 0, 0, IM, 12);
        tbl[23] = v(16'h0000, 16'h0000, 0, 1, 1, 0, 0, IM, 13);
        tbl[24] = v(16'h0000, 16'h0000, 0, 0, 0, 0, 0, RA, 14);
        tbl[25] = v(16'h0000, 16'h0000, 1, 1, 0, 0, 0, IM, 14);  // imiss beats branch in RUN
        tbl[26] = v(16'h0000, 16'h0000, 1, 1, 0, 0, 0, BR, 15);  // redirect inside IMISS
        tbl[27] = v(16'h0135, 16'h8310, 0, 1, 0, 0, 0, LU, 15);
        tbl[28] = v(16'h0000, 16'h0000, 0, 1, 0, 1, 0, FZ, 16);
        tbl[29] = v(16'h0000, 16'h0000, 1, 0, 0, 1, 0, FZ, 17);  // branch ignored in DMISS
        tbl[30] = v(16'h0000, 16'h0000, 0, 0, 0, 0, 1, FZ, 18);
        tbl[31] = v(16'h0000, 16'h0000, 0, 0, 0, 0, 0, RA, 19);

        repeat (2) @(negedge clk);
        #1;
        check_out("in_reset", 0, RA, 1'b0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(tbl[i].ifid, tbl[i].idex, tbl[i].br, tbl[i].im, tbl[i].id,
                  tbl[i].dm, tbl[i].dd, 1'b0);
            check_out("vec", i, tbl[i].ctrl, 1'b0, int'(tbl[i].sc), 1'b0);
        end

        // Long I-miss: timeout after 8 IMISS cycles, counter saturates at 63
        drive(16'h0000, 16'h0000, 0, 1, 0, 0, 0, 0);
        check_out("imiss_entry", 0, IM, 1'b0, 19, 1'b0);
        for (int k = 1; k <= 70; k++) begin
            drive(16'h0000, 16'h0000, 0, 1, 0, 0, 0, 0);
            check_out("imiss_long", k, IM, 1'b0, (19 + k > 63) ? 63 : 19 + k, (k >= 9) ? 1'b1 : 1'b0);
        end

        // Async reset in the middle of a miss
        @(negedge clk);
        icache_miss = 1'b0;
        rst = 1'b0;
        #2;
        check_out("rst_mid_miss", 0, RA, 1'b0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_out("rst_release", 0, RA, 1'b0, 0, 1'b0);

        // Halt: entry cycle advances even with a D-miss, then permanent freeze
        drive(16'h0000, 16'h0000, 0, 0, 0, 1, 0, 1);
        check_out("halt_entry", 0, RA, 1'b0, 0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            drive(16'h0135, 16'h8310, k[0], k[1], k[2], 0, 1, 0);
            check_out("halted", k, FZ, 1'b1, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
